context_cache: RTL and testbench
================================

// Module: context_cache
// PURPOSE
//  Register-file cache of thread contexts (slot array + per-slot status) for the lcisc thread engine.
//  - Accepts user-inserted threads and exposes a waiting count plus the next ready id to the scheduler.
//  - Hands a context out to the executor on request.
//  - Absorbs the returned context with delete/sleep/transform/fork disposition.
// PARAMETERS
//  opcode_size  4  number of MSBs of a context that form its opcode field (transferred by "pass")
// PORTS
//  clk                      in   1     single clock, rising edge
//  rst                      in   1     reset, asynchronous, active-low
//  user_insert              in   1     insert incoming_user_thread into a free slot this cycle
//  incoming_user_thread     in   thread_register_union_t  context to insert
//  incoming_user_status     in   thread_status_t          initial status of inserted thread
//  user_insert_id           out  thread_id_t  slot taken by the last successful user insert
//  waiting_thread_count     out  thread_id_t  number of slots whose status is work_queue
//  waiting_next_id          out  thread_id_t  lowest-index slot in work_queue (0 if none)
//  requesting_thread        in   1     executor pulls a slot
//  requested_thread_id      in   thread_id_t  slot to pull
//  requested_thread_return  out  thread_register_union_t  pulled context
//  out_thread_id            out  thread_id_t  id of pulled context
//  incoming_control         in   ContextCache_Control  return disposition (struct, see STRUCTURE)
//  incoming_thread          in   thread_register_union_t  context returned by executor
// BEHAVIOUR
//  - Reset: all slots = 0 with status no_thread; alloc pointer = 0.
//    - All outputs reset to 0.
//  - Slots: N = 2**$bits(thread_id_t).
//    - Status enum: no_thread, work_queue, executing, sleeping.
//  - All state and outputs are registered; every effect is visible one rising edge after the inputs.
//  - waiting_thread_count: popcount of status==work_queue over registered state.
//  - waiting_next_id: derived from registered state.
//  - Allocation:
//    - Round-robin pointer. The search starts at the pointer for the first no_thread slot (wrapping).
//    - The pointer moves to winner+1 after each allocation.
//    - A freed slot is NOT reused until the pointer wraps to it.
//  - User insert:
//    - Allocated slot <= incoming_user_thread; its status <= incoming_user_status.
//    - user_insert_id <= slot.
//    - No free slot: insert dropped, user_insert_id holds.
//  - Request:
//    - requested_thread_return <= ctx[id]; out_thread_id <= id.
//    - If status was work_queue it becomes executing; otherwise status is unchanged.
//    - Outputs hold when requesting_thread=0.
//  - Return (incoming_control.incoming=1) writes slot incoming_id:
//    - delete=1 (priority): ctx <= 0, status <= no_thread. Execute and fork fields are ignored.
//    - Otherwise status <= sleep ? sleeping : work_queue.
//    - ctx per execute_info:
//      - none: incoming_thread.
//      - pass: incoming_thread with the top opcode_size bits replaced by those of ctx[execute_id].
//      - copy: ctx[execute_id] (full copy).
//  - Fork (no delete, forking_info!=no_fork):
//    - Allocates one extra slot, with status <= fork_sleep ? sleeping : work_queue.
//    - Child ctx per forking_info:
//      - fork_me_copy: incoming_thread unmodified.
//      - fork_other_copy: ctx[forking_id].
//      - fork_other_pass: incoming_thread with top opcode_size bits from ctx[forking_id].
//    - No free slot: fork dropped; the parent write still happens.
//  - Simultaneous events in one cycle:
//    - Insert and fork both allocate; the user insert takes the first free slot, the fork the next.
//    - All ctx sources (execute_id, forking_id, requested_thread_id) read pre-edge state.
//    - Same-slot conflict: return write > request status update.
// STRUCTURE
//  - Package ContextCache_pkg:
//    - thread_status_t.
//    - execute_info enum (none, pass, copy).
//    - forking_info enum (no_fork, fork_me_copy, fork_other_copy, fork_other_pass).
//    - struct ContextCache_Control {incoming, incoming_id, delete, sleep, execute_info, execute_id,
//      forking_info, fork_sleep, forking_id}.
//  - thread_register_union_t (fields .all, .u32[]) and thread_id_t come from EV_types.
//  - Single sub-module free_slot_finder: round-robin first-free search returning the first and second free ids.
// TESTING
//  - Reset, then insert A,B,C (work_queue) -> user_insert_id 0,1,2; waiting_thread_count 1,2,3.
//  - Request id1 -> return==B, out_thread_id 1, count 2; return B, none, sleep=0 -> slot1==B, work_queue, count 3.
//  - Return A to slot0, pass, execute_id=1 -> slot0 = A low bits + B top 4 bits; copy execute_id=1 into slot2 -> slot2==B.
//  - Return slot0 with delete=1 -> ctx 0, no_thread, count 2; next insert -> user_insert_id 3 (no reuse of 0).
//  - Return A at slot3, fork_other_pass, forking_id=1 -> slot4 = B opcode over A, slot3==A, count 4.
//  - Return B at slot2, copy execute_id=4, fork_me_copy -> slot5==B, slot2==slot4 contents, count 5.

Source files
------------

// File: rtl/context_cache_pkg.sv
// ---------------------------------------------------------------------------
// Shared types for the lcisc thread engine context cache.
//
// EV_types        : engine-wide thread id and thread register (context) types.
// ContextCache_pkg: slot status, return disposition enums and the control
//                   struct the executor hands back with a returned context.
// ---------------------------------------------------------------------------
package EV_types;

  localparam int THREAD_ID_W = 3;
  localparam int CTX_W       = 64;

  typedef logic [THREAD_ID_W-1:0] thread_id_t;

  // A context can be viewed as one flat vector or as 32-bit words.
  typedef union packed {
    logic [CTX_W-1:0]              all;
    logic [CTX_W/32-1:0][31:0]     u32;
  } thread_register_union_t;

endpackage

package ContextCache_pkg;

  import EV_types::*;

  localparam int NUM_SLOTS = 2 ** $bits(thread_id_t);

  typedef enum logic [1:0] {
    no_thread,
    work_queue,
    executing,
    sleeping
  } thread_status_t;

  typedef enum logic [1:0] {
    none,
    pass,
    copy
  } execute_info_t;

  typedef enum logic [1:0] {
    no_fork,
    fork_me_copy,
    fork_other_copy,
    fork_other_pass
  } forking_info_t;

  typedef struct packed {
    logic          incoming;
    thread_id_t    incoming_id;
    logic          delete;
    logic          sleep;
    execute_info_t execute_info;
    thread_id_t    execute_id;
    forking_info_t forking_info;
    logic          fork_sleep;
    thread_id_t    forking_id;
  } ContextCache_Control;

endpackage

// File: rtl/context_cache_free_slot_finder.sv
// ---------------------------------------------------------------------------
// free_slot_finder
// Round-robin search for free slots. Walks the slots starting at 'start'
// (wrapping) and reports the first and second free slot encountered.
//
// Ports:
//   free_mask    in   one bit per slot, 1 = slot is free
//   start        in   slot index where the search begins
//   first_found  out  at least one free slot exists
//   first_id     out  first free slot at or after start
//   second_found out  a second free slot exists
//   second_id    out  next free slot after first_id
// ---------------------------------------------------------------------------
module free_slot_finder
  import EV_types::*;
  import ContextCache_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] free_mask,
  input  thread_id_t           start,
  output logic                 first_found,
  output thread_id_t           first_id,
  output logic                 second_found,
  output thread_id_t           second_id
);

  thread_id_t idx;

  // The index arithmetic is done in thread_id_t width so it wraps naturally.
  always_comb begin
    first_found  = 1'b0;
    first_id     = '0;
    second_found = 1'b0;
    second_id    = '0;
    idx          = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = start + thread_id_t'(i);
      if (free_mask[idx]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_id    = idx;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_id    = idx;
        end
      end
    end
  end

endmodule

// File: rtl/context_cache.sv
// ---------------------------------------------------------------------------
// context_cache
// Register-file cache of thread contexts for the lcisc thread engine. Holds
// one context and one status per slot, accepts user-inserted threads, hands
// contexts to the executor and absorbs returned contexts with a
// delete / sleep / transform / fork disposition.
//
// Ports:
//   clk                     in   rising-edge clock
//   rst                     in   asynchronous active-low reset
//   user_insert             in   insert incoming_user_thread this cycle
//   incoming_user_thread    in   context to insert
//   incoming_user_status    in   initial status of the inserted thread
//   user_insert_id          out  slot taken by the last successful insert
//   waiting_thread_count    out  number of slots in work_queue
//   waiting_next_id         out  lowest work_queue slot (0 if none)
//   requesting_thread       in   executor pulls a slot
//   requested_thread_id     in   slot to pull
//   requested_thread_return out  pulled context
//   out_thread_id           out  id of the pulled context
//   incoming_control        in   return disposition
//   incoming_thread         in   context returned by the executor
// ---------------------------------------------------------------------------
module context_cache
  import EV_types::*;
  import ContextCache_pkg::*;
#(
  parameter int opcode_size = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   user_insert,
  input  thread_register_union_t incoming_user_thread,
  input  thread_status_t         incoming_user_status,
  output thread_id_t             user_insert_id,
  output thread_id_t             waiting_thread_count,
  output thread_id_t             waiting_next_id,
  input  logic                   requesting_thread,
  input  thread_id_t             requested_thread_id,
  output thread_register_union_t requested_thread_return,
  output thread_id_t             out_thread_id,
  input  ContextCache_Control    incoming_control,
  input  thread_register_union_t incoming_thread
);

  localparam logic [CTX_W-1:0] OPCODE_MASK = ~({CTX_W{1'b1}} >> opcode_size);

  // Opcode field (top bits) from src, everything else from base.
  function automatic logic [CTX_W-1:0] merge_opcode(input logic [CTX_W-1:0] base,
                                                    input logic [CTX_W-1:0] src);
    return (src & OPCODE_MASK) | (base & ~OPCODE_MASK);
  endfunction

  thread_register_union_t ctx    [NUM_SLOTS];
  thread_status_t         status [NUM_SLOTS];
  thread_id_t             alloc_ptr;

  logic [NUM_SLOTS-1:0]   free_mask;
  logic                   first_found;
  logic                   second_found;
  thread_id_t             first_id;
  thread_id_t             second_id;

  logic                   insert_ok;
  logic                   fork_req;
  logic                   fork_ok;
  thread_id_t             fork_id;
  thread_id_t             next_ptr;

  thread_register_union_t exec_src;
  thread_register_union_t fork_src;
  thread_register_union_t parent_ctx;
  thread_register_union_t child_ctx;
  thread_status_t         parent_status;
  thread_status_t         child_status;

  int                     wq_count;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_mask[i] = (status[i] == no_thread);
    end
  end

  free_slot_finder u_finder (
    .free_mask    (free_mask),
    .start        (alloc_ptr),
    .first_found  (first_found),
    .first_id     (first_id),
    .second_found (second_found),
    .second_id    (second_id)
  );

  // The user insert always gets the first free slot; a fork in the same
  // cycle falls back to the second. The pointer moves past the last winner.
  always_comb begin
    insert_ok = user_insert && first_found;
    fork_req  = incoming_control.incoming && !incoming_control.delete &&
                (incoming_control.forking_info != no_fork);
    fork_ok   = fork_req && (user_insert ? second_found : first_found);
    fork_id   = user_insert ? second_id : first_id;
    next_ptr  = alloc_ptr;
    if (fork_ok) begin
      next_ptr = fork_id + thread_id_t'(1);
    end else if (insert_ok) begin
      next_ptr = first_id + thread_id_t'(1);
    end
  end

  // Every context source reads the pre-edge slot contents.
  always_comb begin
    exec_src   = ctx[incoming_control.execute_id];
    fork_src   = ctx[incoming_control.forking_id];
    parent_ctx = incoming_thread;
    child_ctx  = incoming_thread;
    case (incoming_control.execute_info)
      pass:    parent_ctx.all = merge_opcode(incoming_thread.all, exec_src.all);
      copy:    parent_ctx     = exec_src;
      default: parent_ctx     = incoming_thread;
    endcase
    case (incoming_control.forking_info)
      fork_other_copy: child_ctx     = fork_src;
      fork_other_pass: child_ctx.all = merge_opcode(incoming_thread.all, fork_src.all);
      default:         child_ctx     = incoming_thread;
    endcase
    parent_status = incoming_control.sleep      ? sleeping : work_queue;
    child_status  = incoming_control.fork_sleep ? sleeping : work_queue;
  end

  // Writes are ordered so that the return write lands last and wins over a
  // request status update aimed at the same slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ctx[i]    <= '0;
        status[i] <= no_thread;
      end
      alloc_ptr               <= '0;
      user_insert_id          <= '0;
      requested_thread_return <= '0;
      out_thread_id           <= '0;
    end else begin
      if (requesting_thread) begin
        requested_thread_return <= ctx[requested_thread_id];
        out_thread_id           <= requested_thread_id;
        if (status[requested_thread_id] == work_queue) begin
          status[requested_thread_id] <= executing;
        end
      end
      if (insert_ok) begin
        ctx[first_id]    <= incoming_user_thread;
        status[first_id] <= incoming_user_status;
        user_insert_id   <= first_id;
      end
      if (fork_ok) begin
        ctx[fork_id]    <= child_ctx;
        status[fork_id] <= child_status;
      end
      if (incoming_control.incoming) begin
        if (incoming_control.delete) begin
          ctx[incoming_control.incoming_id]    <= '0;
          status[incoming_control.incoming_id] <= no_thread;
        end else begin
          ctx[incoming_control.incoming_id]    <= parent_ctx;
          status[incoming_control.incoming_id] <= parent_status;
        end
      end
      alloc_ptr <= next_ptr;
    end
  end

  // With every slot in work_queue the count wraps to 0 in thread_id_t width.
  always_comb begin
    wq_count        = 0;
    waiting_next_id = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (status[i] == work_queue) begin
        wq_count        = wq_count + 1;
        waiting_next_id = thread_id_t'(i);
      end
    end
    waiting_thread_count = thread_id_t'(wq_count);
  end

endmodule

// File: tb/tb_context_cache.sv
// ---------------------------------------------------------------------------
// tb_context_cache
// Directed bench for context_cache. The driver pushes hand-computed expected
// outputs into a scoreboard queue tagged with the cycle they become visible;
// a monitor on the falling edge pops due entries and compares them.
// ---------------------------------------------------------------------------
module tb_context_cache;

  import EV_types::*;
  import ContextCache_pkg::*;

  localparam logic [63:0] A  = 64'hA1A2_A3A4_A5A6_A7A8;
  localparam logic [63:0] B  = 64'hB1B2_B3B4_B5B6_B7B8;
  localparam logic [63:0] C  = 64'hC1C2_C3C4_C5C6_C7C8;
  localparam logic [63:0] BA = 64'hB1A2_A3A4_A5A6_A7A8;

  localparam int SEL_UID   = 0;
  localparam int SEL_COUNT = 1;
  localparam int SEL_NEXT  = 2;
  localparam int SEL_RET   = 3;
  localparam int SEL_OID   = 4;

  logic                   clk;
  logic                   rst;
  logic                   user_insert;
  thread_register_union_t incoming_user_thread;
  thread_status_t         incoming_user_status;
  thread_id_t             user_insert_id;
  thread_id_t             waiting_thread_count;
  thread_id_t             waiting_next_id;
  logic                   requesting_thread;
  thread_id_t             requested_thread_id;
  thread_register_union_t requested_thread_return;
  thread_id_t             out_thread_id;
  ContextCache_Control    incoming_control;
  thread_register_union_t incoming_thread;

  typedef struct {
    int          due;
    string       name;
    int          sel;
    logic [63:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t cur;
  int        cycle;
  int        tests_run;
  int        tests_failed;

  context_cache #(.opcode_size(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .user_insert             (user_insert),
    .incoming_user_thread    (incoming_user_thread),
    .incoming_user_status    (incoming_user_status),
    .user_insert_id          (user_insert_id),
    .waiting_thread_count    (waiting_thread_count),
    .waiting_next_id         (waiting_next_id),
    .requesting_thread       (requesting_thread),
    .requested_thread_id     (requested_thread_id),
    .requested_thread_return (requested_thread_return),
    .out_thread_id           (out_thread_id),
    .incoming_control        (incoming_control),
    .incoming_thread         (incoming_thread)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input sb_entry_t e);
    logic [63:0] act;
    case (e.sel)
      SEL_UID:   act = 64'(user_insert_id);
      SEL_COUNT: act = 64'(waiting_thread_count);
      SEL_NEXT:  act = 64'(waiting_next_id);
      SEL_RET:   act = requested_thread_return.all;
      default:   act = 64'(out_thread_id);
    endcase
    tests_run++;
    if (act !== e.exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      cur = sb.pop_front();
      checkOutput(cur);
    end
  end

  task automatic expect_out(input string name, input int sel, input logic [63:0] exp);
    sb_entry_t e;
    e.due  = cycle + 1;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    user_insert          = 1'b0;
    incoming_user_thread = '0;
    incoming_user_status = no_thread;
    requesting_thread    = 1'b0;
    requested_thread_id  = '0;
    incoming_control     = '0;
    incoming_thread      = '0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_insert(input logic [63:0] t, input thread_status_t st);
    user_insert              = 1'b1;
    incoming_user_thread.all = t;
    incoming_user_status     = st;
  endtask

  task automatic set_request(input thread_id_t id);
    requesting_thread   = 1'b1;
    requested_thread_id = id;
  endtask

  task automatic set_return(input thread_id_t id, input logic [63:0] t, input logic del,
                            input logic slp, input execute_info_t ei, input thread_id_t eid,
                            input forking_info_t fi, input logic fslp, input thread_id_t fid);
    incoming_control.incoming     = 1'b1;
    incoming_control.incoming_id  = id;
    incoming_control.delete       = del;
    incoming_control.sleep        = slp;
    incoming_control.execute_info = ei;
    incoming_control.execute_id   = eid;
    incoming_control.forking_info = fi;
    incoming_control.fork_sleep   = fslp;
    incoming_control.forking_id   = fid;
    incoming_thread.all           = t;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cycle        = 0;
    rst          = 1'b0;
    clear_inputs();

    // Reset values, due immediately.
    sb.push_back('{0, "reset_uid",   SEL_UID,   64'd0});
    sb.push_back('{0, "reset_count", SEL_COUNT, 64'd0});
    sb.push_back('{0, "reset_next",  SEL_NEXT,  64'd0});
    sb.push_back('{0, "reset_ret",   SEL_RET,   64'd0});
    sb.push_back('{0, "reset_oid",   SEL_OID,   64'd0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    set_insert(A, work_queue);
    expect_out("ins_a_uid", SEL_UID, 0);  expect_out("ins_a_cnt", SEL_COUNT, 1);
    applyStimulus();
    set_insert(B, work_queue);
    expect_out("ins_b_uid", SEL_UID, 1);  expect_out("ins_b_cnt", SEL_COUNT, 2);
    applyStimulus();
    set_insert(C, work_queue);
    expect_out("ins_c_uid", SEL_UID, 2);  expect_out("ins_c_cnt", SEL_COUNT, 3);
    expect_out("ins_c_next", SEL_NEXT, 0);
    applyStimulus();

    set_request(1);
    expect_out("req1_ret", SEL_RET, B); expect_out("req1_oid", SEL_OID, 1);
    expect_out("req1_cnt", SEL_COUNT, 2);
    applyStimulus();
    set_return(1, B, 0, 0, none, 0, no_fork, 0, 0);
    expect_out("ret1_cnt", SEL_COUNT, 3); expect_out("ret1_hold", SEL_RET, B);
    applyStimulus();
    set_request(1);
    expect_out("req1b_ret", SEL_RET, B); expect_out("req1b_cnt", SEL_COUNT, 2);
    applyStimulus();
    set_return(1, B, 0, 0, none, 0, no_fork, 0, 0);
    expect_out("ret1b_cnt", SEL_COUNT, 3);
    applyStimulus();

    set_return(0, A, 0, 0, pass, 1, no_fork, 0, 0);
    expect_out("pass_cnt", SEL_COUNT, 3);
    applyStimulus();
    set_request(0);
    expect_out("pass_ret", SEL_RET, BA); expect_out("pass_oid", SEL_OID, 0);
    expect_out("pass_cnt2", SEL_COUNT, 2); expect_out("pass_next", SEL_NEXT, 1);
    applyStimulus();
    set_return(2, A, 0, 0, copy, 1, no_fork, 0, 0);
    expect_out("copy_cnt", SEL_COUNT, 2);
    applyStimulus();
    set_request(2);
    expect_out("copy_ret", SEL_RET, B); expect_out("copy_cnt2", SEL_COUNT, 1);
    applyStimulus();

    set_return(0, A, 1, 0, pass, 1, fork_me_copy, 0, 1);
    expect_out("del_cnt", SEL_COUNT, 1); expect_out("del_next", SEL_NEXT, 1);
    applyStimulus();
    set_request(0);
    expect_out("del_ret", SEL_RET, 0); expect_out("del_cnt2", SEL_COUNT, 1);
    applyStimulus();
    set_insert(C, work_queue);
    expect_out("noreuse_uid", SEL_UID, 3); expect_out("noreuse_cnt", SEL_COUNT, 2);
    applyStimulus();

    set_return(3, A, 0, 0, none, 0, fork_other_pass, 0, 1);
    expect_out("fop_cnt", SEL_COUNT, 3);
    applyStimulus();
    set_request(4);
    expect_out("fop_child", SEL_RET, BA); expect_out("fop_oid", SEL_OID, 4);
    applyStimulus();
    set_request(3);
    expect_out("fop_parent", SEL_RET, A); expect_out("fop_cnt2", SEL_COUNT, 1);
    applyStimulus();

    set_return(2, B, 0, 0, copy, 4, fork_me_copy, 0, 0);
    expect_out("fmc_cnt", SEL_COUNT, 3);
    applyStimulus();
    set_request(5);
    expect_out("fmc_child", SEL_RET, B); expect_out("fmc_cnt2", SEL_COUNT, 2);
    applyStimulus();
    set_request(2);
    expect_out("fmc_parent", SEL_RET, BA); expect_out("fmc_cnt3", SEL_COUNT, 1);
    applyStimulus();

    set_insert(C, work_queue);
    set_return(3, A, 0, 1, none, 0, fork_me_copy, 0, 0);
    expect_out("both_uid", SEL_UID, 6); expect_out("both_cnt", SEL_COUNT, 3);
    applyStimulus();
    set_request(7);
    expect_out("both_fork", SEL_RET, A); expect_out("both_cnt2", SEL_COUNT, 2);
    applyStimulus();

    set_insert(C, sleeping);
    expect_out("wrap_uid", SEL_UID, 0); expect_out("wrap_cnt", SEL_COUNT, 2);
    applyStimulus();
    set_insert(A, work_queue);
    expect_out("full_uid", SEL_UID, 0); expect_out("full_cnt", SEL_COUNT, 2);
    applyStimulus();
    set_return(4, C, 0, 0, none, 0, fork_me_copy, 0, 0);
    expect_out("fulfork_cnt", SEL_COUNT, 3);
    applyStimulus();
    set_request(4);
    expect_out("fulfork_ret", SEL_RET, C); expect_out("fulfork_cnt2", SEL_COUNT, 2);
    applyStimulus();
    set_request(1);
    expect_out("req_last_cnt", SEL_COUNT, 1); expect_out("req_last_next", SEL_NEXT, 6);
    applyStimulus();

    set_request(6);
    set_return(6, A, 0, 0, none, 0, no_fork, 0, 0);
    expect_out("conf_ret", SEL_RET, C); expect_out("conf_cnt", SEL_COUNT, 1);
    expect_out("conf_next", SEL_NEXT, 6);
    applyStimulus();
    set_request(6);
    expect_out("conf_ret2", SEL_RET, A); expect_out("conf_cnt2", SEL_COUNT, 0);
    expect_out("conf_next2", SEL_NEXT, 0);
    applyStimulus();

    repeat (3) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: never checked, expected %h", cur.name, cur.exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
